// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, fixed XLEN+1 cycle
//               latency from accept to done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int c_cnt_w = $clog2(XLEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_mulhu  = 3'd3;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_cnt_w-1:0]  r_count;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_m;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_div0;

    logic                w_accept;
    logic                w_last;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_add;
    logic [XLEN:0]       w_shift;
    logic                w_fits;
    logic [XLEN-1:0]     w_diff;
    logic [XLEN-1:0]     w_hi_n;
    logic [XLEN-1:0]     w_lo_n;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_res;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_next = c_st_calc;
            c_st_calc: if (r_count == c_last) w_state_next = c_st_done;
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    assign w_accept = (r_state == c_st_idle) && start;
    assign w_last   = (r_state == c_st_calc) && (r_count == c_last);
    assign busy     = (r_state != c_st_idle);
    assign done     = (r_state == c_st_done);

    // ---------------- operand preparation ----------------
    assign w_sgn_a = (op == c_op_mulh) || (op == c_op_mulhsu) ||
                     (op == c_op_div)  || (op == c_op_rem);
    assign w_sgn_b = (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
    assign w_neg_a = w_sgn_a && rs1_val[XLEN-1];
    assign w_neg_b = w_sgn_b && rs2_val[XLEN-1];
    assign w_mag_a = w_neg_a ? (-rs1_val) : rs1_val;
    assign w_mag_b = w_neg_b ? (-rs2_val) : rs2_val;

    // ---------------- one iteration ----------------
    // Multiply: {r_hi,r_lo} is the product register, r_lo starts as multiplier.
    // Divide:   r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_fits  = (w_shift >= {1'b0, r_m});
    assign w_diff  = w_shift[XLEN-1:0] - r_m;

    always_comb begin
        w_hi_n = w_add[XLEN:1];
        w_lo_n = {w_add[0], r_lo[XLEN-1:1]};
        if (r_op[2]) begin
            w_hi_n = w_fits ? w_diff : w_shift[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], w_fits};
        end
    end

    // ---------------- sign fix-up and result select ----------------
    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg_res ? (-w_prod) : w_prod;
    assign w_quo    = r_neg_res ? (-w_lo_n) : w_lo_n;
    assign w_rem    = r_neg_rem ? (-w_hi_n) : w_hi_n;

    always_comb begin
        w_res = w_prod_s[XLEN-1:0];
        case (r_op)
            c_op_mul:                          w_res = w_prod_s[XLEN-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu: w_res = w_prod_s[2*XLEN-1:XLEN];
            c_op_div, c_op_divu:               w_res = r_div0 ? {XLEN{1'b1}} : w_quo;
            c_op_rem, c_op_remu:               w_res = w_rem;
            default:                           w_res = w_prod_s[XLEN-1:0];
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_op      <= '0;
            r_rd      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_m       <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_op      <= op;
            r_rd      <= rd_in;
            r_hi      <= '0;
            r_lo      <= op[2] ? w_mag_a : w_mag_b;
            r_m       <= op[2] ? w_mag_b : w_mag_a;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_div0    <= (rs2_val == '0);
        end else if (r_state == c_st_calc) begin
            r_count <= r_count + 1'b1;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            if (w_last) begin
                result <= w_res;
                rd_out <= r_rd;
            end
        end
    end

endmodule
`default_nettype wire
